// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite response codes and register map indices
// Used by both the read-side responder and the write-side register file.
package axi_lite_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

    // Word-register map: index = byte address >> 2
    localparam int REG_IRQ_STATUS  = 0;
    localparam int REG_IRQ_ENABLE  = 1;
    localparam int REG_STATUS_BASE = 2;

endpackage

// File: rtl/irq_status_reg.sv
// rtl/irq_status_reg.sv - sticky interrupt status with clear-on-read and masked level output
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   irq_set      per-bit set pulses (set wins over a same-cycle clear)
//   irq_clr      per-bit clear mask, non-zero only on an accepted status read
//   irq_enable   interrupt enable mask
//   irq_status   current sticky status
//   irq_out      registered OR of (next status & enable)
module irq_status_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] irq_set,
    input  logic [WIDTH-1:0] irq_clr,
    input  logic [WIDTH-1:0] irq_enable,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq_out
);

    logic [WIDTH-1:0] status_next;

    // Set is ORed in after the clear so a bit raised during its own read survives.
    assign status_next = (irq_status & ~irq_clr) | irq_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_status <= '0;
            irq_out    <= 1'b0;
        end else begin
            irq_status <= status_next;
            irq_out    <= |(status_next & irq_enable);
        end
    end

endmodule

// File: rtl/axi_lite_read_slave.sv
// rtl/axi_lite_read_slave.sv - AXI4-Lite read responder for accelerator status and interrupt registers
// Ports:
//   ACLK, ARESETn               clock, asynchronous active-low reset
//   ARADDR/ARPROT/ARVALID/ARREADY   read address channel (ARPROT ignored)
//   RDATA/RRESP/RVALID/RREADY       read data channel
//   status_in                   live status words for registers 2..NUM_REGS-1
//   irq_enable, irq_set         interrupt mask and set pulses
//   irq_out                     level interrupt
//   rd_strobe, rd_index         one-cycle pulse and register index per accepted read
module axi_lite_read_slave
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                                ACLK,
    input  logic                                ARESETn,
    input  logic [ADDR_WIDTH-1:0]               ARADDR,
    input  logic [2:0]                          ARPROT,
    input  logic                                ARVALID,
    output logic                                ARREADY,
    output logic [DATA_WIDTH-1:0]               RDATA,
    output logic [1:0]                          RRESP,
    output logic                                RVALID,
    input  logic                                RREADY,
    input  logic [(NUM_REGS-2)*DATA_WIDTH-1:0]  status_in,
    input  logic [DATA_WIDTH-1:0]               irq_enable,
    input  logic [DATA_WIDTH-1:0]               irq_set,
    output logic                                irq_out,
    output logic                                rd_strobe,
    output logic [$clog2(NUM_REGS)-1:0]         rd_index
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int RI_W  = $clog2(NUM_REGS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic                  ar_hs;
    logic                  r_hs;
    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  hit_irq_status;
    logic [DATA_WIDTH-1:0] rd_word;
    axi_resp_t             rd_resp;
    logic [DATA_WIDTH-1:0] irq_status;
    logic [DATA_WIDTH-1:0] irq_clr;

    // Protection bits and byte offset carry no meaning for word registers.
    logic unused_inputs;
    assign unused_inputs = ^{ARPROT, ARADDR[1:0]};

    // ARREADY is only ever high in IDLE, so it alone qualifies the AR handshake.
    assign ar_hs    = ARVALID && ARREADY;
    assign r_hs     = RVALID && RREADY;
    assign idx      = ARADDR[ADDR_WIDTH-1:2];
    assign in_range = (idx < IDX_W'(NUM_REGS));
    assign hit_irq_status = in_range && (idx == IDX_W'(REG_IRQ_STATUS));

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        if (!in_range) begin
            rd_resp = RESP_SLVERR;
        end else if (idx == IDX_W'(REG_IRQ_STATUS)) begin
            rd_word = irq_status;
        end else if (idx == IDX_W'(REG_IRQ_ENABLE)) begin
            rd_word = irq_enable;
        end else begin
            for (int k = 0; k < NUM_REGS - REG_STATUS_BASE; k++) begin
                if (idx == IDX_W'(k + REG_STATUS_BASE)) begin
                    rd_word = status_in[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Clear exactly the bits that the host is being shown.
    assign irq_clr = (ar_hs && hit_irq_status) ? irq_status : '0;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (ar_hs) state_next = ST_RESP;
            ST_RESP: if (r_hs)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= ST_IDLE;
            ARREADY   <= 1'b0;
            RVALID    <= 1'b0;
            RDATA     <= '0;
            RRESP     <= RESP_OKAY;
            rd_strobe <= 1'b0;
            rd_index  <= '0;
        end else begin
            state     <= state_next;
            ARREADY   <= (state_next == ST_IDLE);
            RVALID    <= (state_next == ST_RESP);
            rd_strobe <= ar_hs;
            // Capture at the handshake so later status changes cannot disturb a held response.
            if (ar_hs) begin
                RDATA    <= rd_word;
                RRESP    <= rd_resp;
                rd_index <= in_range ? idx[RI_W-1:0] : '0;
            end
        end
    end

    irq_status_reg #(
        .WIDTH(DATA_WIDTH)
    ) u_irq_status_reg (
        .clk        (ACLK),
        .rst_n      (ARESETn),
        .irq_set    (irq_set),
        .irq_clr    (irq_clr),
        .irq_enable (irq_enable),
        .irq_status (irq_status),
        .irq_out    (irq_out)
    );

endmodule

// File: tb/tb_axi_lite_read_slave.sv
// tb/tb_axi_lite_read_slave.sv - scoreboard bench for axi_lite_read_slave
module tb_axi_lite_read_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;

    logic                   ACLK = 1'b0;
    logic                   ARESETn;
    logic [AW-1:0]          ARADDR;
    logic [2:0]             ARPROT;
    logic                   ARVALID;
    logic                   ARREADY;
    logic [DW-1:0]          RDATA;
    logic [1:0]             RRESP;
    logic                   RVALID;
    logic                   RREADY;
    logic [(NR-2)*DW-1:0]   status_in;
    logic [DW-1:0]          irq_enable;
    logic [DW-1:0]          irq_set;
    logic                   irq_out;
    logic                   rd_strobe;
    logic [2:0]             rd_index;

    axi_lite_read_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP),
        .RVALID(RVALID), .RREADY(RREADY), .status_in(status_in),
        .irq_enable(irq_enable), .irq_set(irq_set), .irq_out(irq_out),
        .rd_strobe(rd_strobe), .rd_index(rd_index)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    rsp_t        sb[$];
    logic [33:0] got_q[$];
    bit          rnd_on = 0;

    // Reference state: what the register map should look like after the last edge
    logic [31:0] m_irq;
    bit          m_busy;
    bit          m_ready;
    bit          m_irq_out;
    bit          m_strobe;
    int          m_index;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: condition not met at %0t", name, $time);
    endtask

    task automatic check_got(input string name, input int i, input logic [33:0] exp);
        if (got_q.size() > i) chk(name, got_q[i], exp);
        else fail_now({name, "_missing"});
    endtask

    // Register map read, straight from the address map rules
    function automatic rsp_t ref_read(input logic [31:0] addr);
        rsp_t        r;
        logic [31:0] word_no;
        word_no = addr >> 2;
        r.resp  = 2'b00;
        r.data  = 32'h0;
        if (word_no == 0)       r.data = m_irq;
        else if (word_no == 1)  r.data = irq_enable;
        else if (word_no < NR)  r.data = status_in[(word_no-2)*DW +: DW];
        else                    r.resp = 2'b10;
        return r;
    endfunction

    // Reference model: at each falling edge check outputs of the last rising
    // edge, then predict what the coming rising edge will do.
    initial begin
        logic [31:0] clr;
        logic [31:0] word_no;
        bit          accept;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                m_irq = 0; m_busy = 0; m_ready = 0; m_irq_out = 0;
                m_strobe = 0; m_index = 0;
                sb.delete();
            end else begin
                chk("arready", ARREADY, m_ready);
                chk("rvalid", RVALID, m_busy);
                chk("irq_out", irq_out, m_irq_out);
                chk("rd_strobe", rd_strobe, m_strobe);
                if (m_strobe) chk("rd_index", rd_index, m_index);

                accept = ARVALID && m_ready;
                clr    = 32'h0;
                if (accept) begin
                    word_no = ARADDR >> 2;
                    sb.push_back(ref_read(ARADDR));
                    if (word_no == 0) clr = m_irq;
                    m_index = (word_no < NR) ? int'(word_no) : 0;
                end
                m_strobe  = accept;
                m_irq     = (m_irq & ~clr) | irq_set;
                m_irq_out = |(m_irq & irq_enable);
                m_busy    = m_busy ? !RREADY : accept;
                m_ready   = !m_busy;
            end
        end
    end

    // Monitor: every presented response must match the oldest expected one.
    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESETn && RVALID) begin
                if (sb.size() == 0) begin
                    fail_now("rvalid_unexpected");
                end else begin
                    chk("rdata", RDATA, sb[0].data);
                    chk("rresp", RRESP, sb[0].resp);
                    if (RREADY) begin
                        void'(sb.pop_front());
                        got_q.push_back({RRESP, RDATA});
                    end
                end
            end
        end
    end

    // Random background stimulus
    initial begin
        forever begin
            @(posedge ACLK);
            #2;
            if (rnd_on) begin
                RREADY  = ($urandom_range(0, 3) != 0);
                irq_set = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
                for (int k = 0; k < NR-2; k++) status_in[k*DW +: DW] = $urandom;
                if ($urandom_range(0, 15) == 0) irq_enable = $urandom;
            end
        end
    end

    task automatic cyc();
        @(posedge ACLK);
        #2;
    endtask

    task automatic issue(input logic [31:0] a);
        bit ok;
        ok      = 0;
        ARVALID = 1'b1;
        ARADDR  = a;
        ARPROT  = 3'($urandom);
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge ACLK);
            ok = ARREADY;
            @(posedge ACLK);
            #2;
        end
        ARVALID = 1'b0;
        if (!ok) fail_now("ar_timeout");
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge ACLK);
            done = (sb.size() == 0) && !RVALID;
        end
        if (!done) fail_now("idle_timeout");
        cyc();
    endtask

    initial begin
        ARESETn = 0; ARVALID = 0; ARADDR = 0; ARPROT = 0; RREADY = 0;
        status_in = '0; irq_enable = 0; irq_set = 0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("reset_arready", ARREADY, 0);
        chk("reset_rvalid", RVALID, 0);
        chk("reset_rdata", RDATA, 0);
        chk("reset_rresp", RRESP, 0);
        chk("reset_irq_out", irq_out, 0);
        chk("reset_rd_strobe", rd_strobe, 0);
        chk("reset_rd_index", rd_index, 0);
        @(posedge ACLK);
        #2;
        ARESETn = 1;

        // Basic status read
        status_in[31:0] = 32'hDEADBEEF;
        RREADY = 1;
        cyc();
        got_q.delete();
        issue(32'h8);
        wait_idle();
        check_got("t1_read", 0, {2'b00, 32'hDEADBEEF});

        // Backpressure with a second AR waiting
        got_q.delete();
        status_in[63:32] = 32'h11111111;
        RREADY = 0;
        issue(32'hC);
        ARVALID = 1; ARADDR = 32'h10;
        for (int i = 0; i < 5; i++) begin
            status_in[63:32] = $urandom;
            cyc();
        end
        RREADY = 1;
        issue(32'h10);
        wait_idle();
        check_got("t2_held_read", 0, {2'b00, 32'h11111111});
        chk("t2_count", got_q.size(), 2);

        // Interrupt assertion and clear-on-read
        got_q.delete();
        irq_enable = 32'h4;
        irq_set = 32'h5;
        cyc();
        irq_set = 0;
        chk("t3_irq_out_high", irq_out, 1);
        issue(32'h0);
        wait_idle();
        check_got("t3_status_read", 0, {2'b00, 32'h5});
        chk("t3_irq_out_low", irq_out, 0);

        // Set and clear of the same bit on the same edge
        got_q.delete();
        irq_set = 32'h1;
        cyc();
        irq_set = 32'h1;
        chk("t4_arready", ARREADY, 1);
        ARVALID = 1; ARADDR = 32'h0;
        cyc();
        ARVALID = 0; irq_set = 0;
        wait_idle();
        issue(32'h0);
        wait_idle();
        check_got("t4_first", 0, {2'b00, 32'h1});
        check_got("t4_set_wins", 1, {2'b00, 32'h1});

        // Out-of-range read
        got_q.delete();
        irq_set = 32'h2;
        cyc();
        irq_set = 0;
        issue(32'h20);
        wait_idle();
        issue(32'h0);
        wait_idle();
        check_got("t5_slverr", 0, {2'b10, 32'h0});
        check_got("t5_status_kept", 1, {2'b00, 32'h2});

        // Reset while a response is pending
        got_q.delete();
        RREADY = 0;
        issue(32'h4);
        chk("t6_rvalid_pre", RVALID, 1);
        #1 ARESETn = 0;
        #1;
        chk("t6_rvalid_async", RVALID, 0);
        chk("t6_arready_async", ARREADY, 0);
        repeat (2) cyc();
        ARESETn = 1;
        RREADY = 1;
        status_in[31:0] = 32'h0BADF00D;
        cyc();
        issue(32'h8);
        wait_idle();
        check_got("t6_after_reset", 0, {2'b00, 32'h0BADF00D});
        chk("t6_count", got_q.size(), 1);

        // Randomized traffic
        rnd_on = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) issue(32'hFFFF_FFFC);
            else issue(32'($urandom_range(0, 11) * 4 + $urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) cyc();
        end
        rnd_on = 0;
        RREADY = 1;
        irq_set = 0;
        wait_idle();
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_read_slave.md
Name: axi_lite_read_slave

Overview:
- AXI4-Lite read-channel responder that exposes the accelerator's status and interrupt registers to the host.
- It is the read-side counterpart of the accelerator's AXI-Lite write path.
- Sits between the interconnect's AR/R channels and the accelerator core's status outputs.
- Owns the sticky interrupt-status register, with clear-on-read, and drives the interrupt line.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width. Only 32 is supported.
- NUM_REGS, 8, number of word registers decoded. Minimum 3.

Ports:
- ACLK  in  1  system clock; all logic on the rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- ARADDR  in  ADDR_WIDTH  read address.
- ARPROT  in  3  protection attributes; accepted and ignored.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- status_in  in  (NUM_REGS-2)*DATA_WIDTH  live status words for registers 2..NUM_REGS-1; slice k maps to register k+2.
- irq_enable  in  DATA_WIDTH  interrupt enable mask, sourced from the write-side register file.
- irq_set  in  DATA_WIDTH  per-bit interrupt set pulses from the core.
- irq_out  out  1  level interrupt to the system.
- rd_strobe  out  1  one-cycle pulse on every accepted read.
- rd_index  out  $clog2(NUM_REGS)  register index of the accepted read; valid when rd_strobe is high.

Behaviour:
- Reset values (asynchronous on ARESETn low):
  - ARREADY=0, RVALID=0, RDATA=0, RRESP=0, irq_out=0, rd_strobe=0, rd_index=0.
  - irq_status=0; state=IDLE.
  - ARREADY rises in the first cycle after reset deassertion.
- FSM with two states, IDLE and RESP:
  - IDLE: ARREADY=1. On ARVALID, the handshake occurs in that cycle; next state is RESP.
  - RESP: ARREADY=0, RVALID=1. RDATA and RRESP are held stable until RVALID&&RREADY; then next state is IDLE.
  - ARREADY is a registered output equal to (state==IDLE).
- Latency and throughput:
  - AR handshake in cycle N gives RVALID high in cycle N+1.
  - Maximum throughput is one read per 2 cycles.
  - No outstanding-read depth beyond 1.
- Address decode:
  - idx = ARADDR[ADDR_WIDTH-1:2]; ARADDR[1:0] is ignored (unaligned reads are treated as aligned).
  - idx==0: IRQ_STATUS, returns irq_status.
  - idx==1: IRQ_ENABLE, returns irq_enable.
  - 2 <= idx < NUM_REGS: returns status_in slice idx-2.
  - idx >= NUM_REGS: RDATA=0, RRESP=SLVERR, no side effects, rd_strobe still pulses with rd_index=0.
  - RDATA is captured at the handshake edge. Later changes on status_in do not affect a pending response.
- IRQ status (sticky, clear-on-read):
  - Each cycle: irq_status <= (irq_status & ~clr) | irq_set.
  - clr = the value returned (all ones of captured data) when an accepted read hits idx==0; otherwise 0.
  - Simultaneous set and clear on the same bit: set wins, and the bit stays 1 for the next read.
- irq_out:
  - Registered: irq_out <= |(irq_status_next & irq_enable).
  - One-cycle delay from irq_set, or from an enable change, to irq_out.
- rd_strobe/rd_index: registered, high in cycle N+1 for a handshake in cycle N.
- Reset mid-transaction: an outstanding response is dropped, and RVALID falls asynchronously. The master must reissue the read.
- RREADY held high in IDLE has no effect. RREADY is not required before RVALID.

Decomposition:
- Shared package axi_lite_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Register index constants REG_IRQ_STATUS=0, REG_IRQ_ENABLE=1, REG_STATUS_BASE=2.
  - The write side uses the same package.
- One natural sub-module, irq_status_reg: sticky set/clear-on-read register plus masked-OR interrupt output.
- The FSM and decode stay in the top module.

Test Plan:
1. Reset, then ARADDR=0x8 with status_in slice0=0xDEADBEEF and RREADY=1 -> ARREADY=1 before the handshake; RVALID in N+1; RDATA=0xDEADBEEF; RRESP=00; rd_index=2.
2. Backpressure: RREADY=0 for 5 cycles while status_in changes -> RDATA and RVALID held constant; ARREADY=0 throughout; a new AR is not accepted until the cycle after the R handshake.
3. Interrupts:
   - Step 1: irq_set=0x5 pulse with irq_enable=0x4 -> irq_out=1 one cycle later.
   - Step 2: read addr 0x0 -> RDATA=0x5; irq_status then 0; irq_out falls.
4. irq_set=0x1 in the same cycle as the handshake of an IRQ_STATUS read returning 0x1 -> the following read returns 0x1 (set wins).
5. ARADDR=NUM_REGS*4 (0x20) -> RRESP=10, RDATA=0; irq_status unchanged.
6. Assert ARESETn=0 while RVALID=1 -> RVALID=0 immediately. After release, a new read completes normally.
